btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//   Front-end conditioning for the lock panel push-buttons (toggle, enter, next, reset).
//   Synchronises raw active-low pins to hw_clk and debounces each one independently.
//   Produces clean active-low levels that feed the lock FSM's btn_* inputs directly.
//   Also produces one-cycle press/release/hold strobes for hw_clk-domain consumers.
// PARAMETERS
//   NUM_BTNS        4          number of independent button channels
//   DEBOUNCE_CYCLES 250000     consecutive stable hw_clk cycles needed to accept a change (~20 ms @12 MHz); >=2
//   HOLD_CYCLES     24000000   hw_clk cycles a clean press must persist before the hold strobe (~2 s); > DEBOUNCE_CYCLES
// PORTS
//   hw_clk       in   1         system clock; all logic on posedge
//   rst          in   1         synchronous, active-high reset
//   btn_raw_n    in   NUM_BTNS  raw pins, active-low (0 = pressed), asynchronous to hw_clk
//   btn_clean_n  out  NUM_BTNS  debounced level, active-low; bit i maps to btn_raw_n[i]
//   btn_press    out  NUM_BTNS  1-cycle strobe on clean 1->0 (press accepted)
//   btn_release  out  NUM_BTNS  1-cycle strobe on clean 0->1 (release accepted)
//   btn_hold     out  NUM_BTNS  1-cycle strobe once per press, after HOLD_CYCLES of continuous clean-low
// BEHAVIOUR
//   Reset (rst=1 at a posedge): all sync flops <= 1; btn_clean_n <= all 1s; all counters <= 0.
//     btn_press, btn_release and btn_hold <= 0. Raw pins are ignored while rst=1.
//   Synchroniser: two-flop chain per bit, s1 <= btn_raw_n, s2 <= s1. Only s2 is used downstream.
//   Per-channel FSM, 2 states keyed on btn_clean_n[i]: UP (clean=1) and DOWN (clean=0).
//   Debounce counter db_cnt[i], width $clog2(DEBOUNCE_CYCLES):
//     - s2 == clean: db_cnt <= 0.
//     - s2 != clean and db_cnt < DEBOUNCE_CYCLES-1: db_cnt <= db_cnt+1.
//     - s2 != clean and db_cnt == DEBOUNCE_CYCLES-1: clean <= s2 and db_cnt <= 0.
//       In the same edge, btn_press (to DOWN) or btn_release (to UP) <= 1 for exactly one cycle.
//   Any glitch, i.e. a single cycle with s2 == clean, restarts the debounce count from 0.
//   Latency: a clean raw step takes 2 + DEBOUNCE_CYCLES edges to appear on btn_clean_n.
//     The matching strobe is registered and coincident with the first cycle of the new clean level.
//   Hold counter hold_cnt[i], width $clog2(HOLD_CYCLES+1):
//     - Cleared on entry to DOWN; increments every cycle while in DOWN.
//     - Asserts btn_hold for one cycle when it reaches HOLD_CYCLES, counted from the btn_press cycle.
//     - Then saturates: no repeat while held. Cleared in UP.
//   A release before HOLD_CYCLES produces no hold strobe.
//   Channels are fully independent. Simultaneous events on different bits each produce their own strobes in the same cycle.
//   press and release are mutually exclusive per bit per cycle.
//   hold and release are mutually exclusive per bit: the release wins and the hold counter clears.
//   Reset mid-debounce or mid-hold: all counts are discarded and no strobe is emitted.
//     A button held through reset release yields btn_press 2+DEBOUNCE_CYCLES edges after rst falls.
//   The channel wired to the lock FSM's reset button is conditioned like any other channel.
//     It is never used as this block's own rst.
//   Outputs are glitch-free registers.
//   btn_clean_n holds each level for at least DEBOUNCE_CYCLES, so the lock FSM's slow-clock edge detect sees at most one edge per press.
// TESTING (bench: NUM_BTNS=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20)
//   1. Reset check: rst=1 for 3 cycles with btn_raw_n=4'b0000.
//      -> btn_clean_n=4'b1111 and all strobes 0 during reset.
//      -> After rst falls, btn_press=4'b1111 pulses at edge 6 and btn_clean_n=4'b0000 from edge 6.
//   2. Clean press on bit0: raw[0] 1->0 and held.
//      -> btn_clean_n[0]=0 and btn_press[0]=1 exactly 6 edges later; press is 1 for one cycle only.
//   3. Bounce on bit1: raw[1] pattern 0,0,0,1,0,0,0,0, then held low.
//      -> No change until 4 stable synced cycles accumulate after the glitch.
//      -> Exactly one btn_press[1] pulse; btn_release[1] stays 0 throughout.
//   4. Hold and release: bit2 pressed for 30 cycles past press acceptance.
//      -> btn_hold[2] pulses exactly 20 edges after btn_press[2], once only.
//      -> On release, btn_release[2] pulses 6 edges after the raw rise.
//      -> Repeat with 10-cycle press: no btn_hold.
//   5. Simultaneous events: bit0 released while bit3 pressed on the same raw edge.
//      -> btn_release[0] and btn_press[3] pulse in the same cycle.
//   6. Reset mid-debounce: rst=1 at db_cnt=2 during bit1 press.
//      -> No press strobe; after reset, debounce restarts and the press arrives 6 edges after rst falls.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, per-channel debounce FSM,
// and registered one-cycle press / release / hold strobes.
module btn_conditioner #(
   parameter int NUM_BTNS        = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 24000000
) (
   input  logic                hw_clk,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn_raw_n,
   output logic [NUM_BTNS-1:0] btn_clean_n,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic [NUM_BTNS-1:0] btn_hold
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

   // Encoding chosen so the state bit is the active-low clean level itself.
   typedef enum logic {
      ST_DOWN = 1'b0,
      ST_UP   = 1'b1
   } btn_state_e;

   logic [NUM_BTNS-1:0] sync1_q;
   logic [NUM_BTNS-1:0] sync2_q;

   // Two-flop synchroniser; reset value 1 means "not pressed".
   always_ff @(posedge hw_clk) begin
      if (rst) begin
         sync1_q <= {NUM_BTNS{1'b1}};
         sync2_q <= {NUM_BTNS{1'b1}};
      end else begin
         sync1_q <= btn_raw_n;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      btn_state_e        state_q, state_d;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              hold_q, hold_d;
      logic              stable_s;
      logic              db_done_s;

      // A single cycle of agreement restarts the debounce window.
      assign stable_s  = (sync2_q[i] == logic'(state_q));
      assign db_done_s = (db_cnt_q == DB_LAST);

      // Next-state, debounce/hold counters and strobe decode for one channel.
      always_comb begin
         state_d    = state_q;
         db_cnt_d   = db_cnt_q;
         hold_cnt_d = hold_cnt_q;
         press_d    = 1'b0;
         release_d  = 1'b0;
         hold_d     = 1'b0;
         case (state_q)
            ST_UP: begin
               hold_cnt_d = '0;
               if (stable_s) begin
                  db_cnt_d = '0;
               end else if (db_done_s) begin
                  state_d  = ST_DOWN;
                  db_cnt_d = '0;
                  press_d  = 1'b1;
               end else begin
                  db_cnt_d = db_cnt_q + DB_W'(1);
               end
            end
            ST_DOWN: begin
               if (!stable_s && db_done_s) begin
                  // Release takes priority over a hold landing on the same edge.
                  state_d    = ST_UP;
                  db_cnt_d   = '0;
                  hold_cnt_d = '0;
                  release_d  = 1'b1;
               end else begin
                  if (stable_s) begin
                     db_cnt_d = '0;
                  end else begin
                     db_cnt_d = db_cnt_q + DB_W'(1);
                  end
                  // Count from the press cycle, fire once, then saturate.
                  if (hold_cnt_q < HOLD_MAX) begin
                     hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                     hold_d     = (hold_cnt_q == HOLD_LAST);
                  end else begin
                     hold_cnt_d = hold_cnt_q;
                  end
               end
            end
            default: begin
               state_d    = ST_UP;
               db_cnt_d   = '0;
               hold_cnt_d = '0;
            end
         endcase
      end

      // Channel state, counters and registered strobes.
      always_ff @(posedge hw_clk) begin
         if (rst) begin
            state_q    <= ST_UP;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
         end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
         end
      end

      assign btn_clean_n[i] = logic'(state_q);
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;
      assign btn_hold[i]    = hold_q;
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20).
// Expected strobes are scheduled into an edge-ordered scoreboard when the
// stimulus is driven and popped at the matching edge.
module tb_btn_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw_n;
   logic [3:0] clean_n;
   logic [3:0] press;
   logic [3:0] release_s;
   logic [3:0] hold;

   int         edge_cnt = 0;
   logic       rst_seen = 1'b0;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      int         edge_no;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] hold;
   } ev_t;

   ev_t        sb[$];
   logic [3:0] exp_press;
   logic [3:0] exp_rel;
   logic [3:0] exp_hold;
   logic [3:0] exp_clean = 4'hF;

   btn_conditioner #(
      .NUM_BTNS       (4),
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (20)
   ) dut (
      .hw_clk     (clk),
      .rst        (rst),
      .btn_raw_n  (raw_n),
      .btn_clean_n(clean_n),
      .btn_press  (press),
      .btn_release(release_s),
      .btn_hold   (hold)
   );

   always #5 clk = ~clk;

   // Edge counter and reset-seen flag, both sampled on the active edge.
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      rst_seen <= rst;
   end

   // Insert an expected event, merging with any event already on that edge.
   function automatic void push_ev(input int e, input logic [3:0] p,
                                   input logic [3:0] r, input logic [3:0] h);
      ev_t ev;
      int  pos;
      bit  merged;
      pos    = sb.size();
      merged = 1'b0;
      for (int k = 0; k < sb.size(); k++) begin
         if (!merged && sb[k].edge_no == e) begin
            ev      = sb[k];
            ev.press = ev.press | p;
            ev.rel   = ev.rel | r;
            ev.hold  = ev.hold | h;
            sb[k]   = ev;
            merged  = 1'b1;
         end else if (!merged && sb[k].edge_no > e && pos == sb.size()) begin
            pos = k;
         end
      end
      if (!merged) begin
         ev.edge_no = e;
         ev.press   = p;
         ev.rel     = r;
         ev.hold    = h;
         sb.insert(pos, ev);
      end
   endfunction

   // Step to the next falling edge and pop the expectation for this edge.
   task automatic advance();
      ev_t ev;
      @(negedge clk);
      exp_press = 4'b0000;
      exp_rel   = 4'b0000;
      exp_hold  = 4'b0000;
      if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
         ev        = sb.pop_front();
         exp_press = ev.press;
         exp_rel   = ev.rel;
         exp_hold  = ev.hold;
      end
      if (rst_seen) exp_clean = 4'hF;
      else          exp_clean = (exp_clean & ~exp_press) | exp_rel;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      raw_n = 4'b0000;
      for (int c = 0; c < 19; c++) begin
         if (c == 3) begin
            rst = 1'b0;
            push_ev(edge_cnt + 6, 4'hF, 4'h0, 4'h0);
         end
         if (c == 11) begin
            raw_n = 4'hF;
            push_ev(edge_cnt + 6, 4'h0, 4'hF, 4'h0);
         end
         advance();
         checks++; if (clean_n !== exp_clean) begin errors++; $display("FAIL reset.clean edge=%0d got=%b exp=%b", edge_cnt, clean_n, exp_clean); end
         checks++; if (press !== exp_press) begin errors++; $display("FAIL reset.press edge=%0d got=%b exp=%b", edge_cnt, press, exp_press); end
         checks++; if (release_s !== exp_rel) begin errors++; $display("FAIL reset.release edge=%0d got=%b exp=%b", edge_cnt, release_s, exp_rel); end
         checks++; if (hold !== exp_hold) begin errors++; $display("FAIL reset.hold edge=%0d got=%b exp=%b", edge_cnt, hold, exp_hold); end
      end
   endtask

   task automatic test_clean_press();
      for (int c = 0; c < 16; c++) begin
         if (c == 0) begin
            raw_n[0] = 1'b0;
            push_ev(edge_cnt + 6, 4'b0001, 4'h0, 4'h0);
         end
         if (c == 8) begin
            raw_n[0] = 1'b1;
            push_ev(edge_cnt + 6, 4'h0, 4'b0001, 4'h0);
         end
         advance();
         checks++; if (clean_n !== exp_clean) begin errors++; $display("FAIL press.clean edge=%0d got=%b exp=%b", edge_cnt, clean_n, exp_clean); end
         checks++; if (press !== exp_press) begin errors++; $display("FAIL press.press edge=%0d got=%b exp=%b", edge_cnt, press, exp_press); end
         checks++; if (release_s !== exp_rel) begin errors++; $display("FAIL press.release edge=%0d got=%b exp=%b", edge_cnt, release_s, exp_rel); end
         checks++; if (hold !== exp_hold) begin errors++; $display("FAIL press.hold edge=%0d got=%b exp=%b", edge_cnt, hold, exp_hold); end
      end
   endtask

   task automatic test_bounce();
      logic [7:0] pat;
      pat = 8'b0000_1000;   // index 0 first: 0,0,0,1,0,0,0,0
      for (int c = 0; c < 22; c++) begin
         if (c == 0) begin
            // Last glitch sample is driven at c=3; stable from c=4, so +4+6.
            push_ev(edge_cnt + 10, 4'b0010, 4'h0, 4'h0);
         end
         if (c < 8) raw_n[1] = pat[c];
         if (c == 14) begin
            raw_n[1] = 1'b1;
            push_ev(edge_cnt + 6, 4'h0, 4'b0010, 4'h0);
         end
         advance();
         checks++; if (clean_n !== exp_clean) begin errors++; $display("FAIL bounce.clean edge=%0d got=%b exp=%b", edge_cnt, clean_n, exp_clean); end
         checks++; if (press !== exp_press) begin errors++; $display("FAIL bounce.press edge=%0d got=%b exp=%b", edge_cnt, press, exp_press); end
         checks++; if (release_s !== exp_rel) begin errors++; $display("FAIL bounce.release edge=%0d got=%b exp=%b", edge_cnt, release_s, exp_rel); end
         checks++; if (hold !== exp_hold) begin errors++; $display("FAIL bounce.hold edge=%0d got=%b exp=%b", edge_cnt, hold, exp_hold); end
      end
   endtask

   task automatic test_hold();
      for (int c = 0; c < 68; c++) begin
         if (c == 0) begin
            raw_n[2] = 1'b0;
            push_ev(edge_cnt + 6, 4'b0100, 4'h0, 4'h0);
            push_ev(edge_cnt + 26, 4'h0, 4'h0, 4'b0100);
         end
         if (c == 36) begin
            raw_n[2] = 1'b1;
            push_ev(edge_cnt + 6, 4'h0, 4'b0100, 4'h0);
         end
         if (c == 44) begin
            raw_n[2] = 1'b0;
            push_ev(edge_cnt + 6, 4'b0100, 4'h0, 4'h0);
         end
         if (c == 60) begin
            raw_n[2] = 1'b1;
            push_ev(edge_cnt + 6, 4'h0, 4'b0100, 4'h0);
         end
         advance();
         checks++; if (clean_n !== exp_clean) begin errors++; $display("FAIL hold.clean edge=%0d got=%b exp=%b", edge_cnt, clean_n, exp_clean); end
         checks++; if (press !== exp_press) begin errors++; $display("FAIL hold.press edge=%0d got=%b exp=%b", edge_cnt, press, exp_press); end
         checks++; if (release_s !== exp_rel) begin errors++; $display("FAIL hold.release edge=%0d got=%b exp=%b", edge_cnt, release_s, exp_rel); end
         checks++; if (hold !== exp_hold) begin errors++; $display("FAIL hold.hold edge=%0d got=%b exp=%b", edge_cnt, hold, exp_hold); end
      end
   endtask

   task automatic test_simultaneous();
      for (int c = 0; c < 24; c++) begin
         if (c == 0) begin
            raw_n[0] = 1'b0;
            push_ev(edge_cnt + 6, 4'b0001, 4'h0, 4'h0);
         end
         if (c == 8) begin
            raw_n[0] = 1'b1;
            raw_n[3] = 1'b0;
            push_ev(edge_cnt + 6, 4'b1000, 4'b0001, 4'h0);
         end
         if (c == 16) begin
            raw_n[3] = 1'b1;
            push_ev(edge_cnt + 6, 4'h0, 4'b1000, 4'h0);
         end
         advance();
         checks++; if (clean_n !== exp_clean) begin errors++; $display("FAIL simul.clean edge=%0d got=%b exp=%b", edge_cnt, clean_n, exp_clean); end
         checks++; if (press !== exp_press) begin errors++; $display("FAIL simul.press edge=%0d got=%b exp=%b", edge_cnt, press, exp_press); end
         checks++; if (release_s !== exp_rel) begin errors++; $display("FAIL simul.release edge=%0d got=%b exp=%b", edge_cnt, release_s, exp_rel); end
         checks++; if (hold !== exp_hold) begin errors++; $display("FAIL simul.hold edge=%0d got=%b exp=%b", edge_cnt, hold, exp_hold); end
      end
   endtask

   task automatic test_reset_mid_debounce();
      for (int c = 0; c < 22; c++) begin
         if (c == 0) raw_n[1] = 1'b0;     // debounce count reaches 2 after 4 edges
         if (c == 4) rst = 1'b1;
         if (c == 6) begin
            rst = 1'b0;
            push_ev(edge_cnt + 6, 4'b0010, 4'h0, 4'h0);
         end
         if (c == 14) begin
            raw_n[1] = 1'b1;
            push_ev(edge_cnt + 6, 4'h0, 4'b0010, 4'h0);
         end
         advance();
         checks++; if (clean_n !== exp_clean) begin errors++; $display("FAIL rstmid.clean edge=%0d got=%b exp=%b", edge_cnt, clean_n, exp_clean); end
         checks++; if (press !== exp_press) begin errors++; $display("FAIL rstmid.press edge=%0d got=%b exp=%b", edge_cnt, press, exp_press); end
         checks++; if (release_s !== exp_rel) begin errors++; $display("FAIL rstmid.release edge=%0d got=%b exp=%b", edge_cnt, release_s, exp_rel); end
         checks++; if (hold !== exp_hold) begin errors++; $display("FAIL rstmid.hold edge=%0d got=%b exp=%b", edge_cnt, hold, exp_hold); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold();
      test_simultaneous();
      test_reset_mid_debounce();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard.drain pending=%0d required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
